// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control logic.
// Contents:
//   FWD_NONE / FWD_MEM / FWD_WB : forwarding select encodings
//   mem_state_e                 : data-memory wait FSM states
//   REG_ZERO                    : architectural zero register number
package mips_pipe_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_RELEASE = 2'b10
  } mem_state_e;

  // Register $0 is hardwired to zero; it is never a real dependency.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_select.sv
// Per-source dependency checker for one ID-stage source operand.
// Ports:
//   i_src, i_used               : source register number and whether it is read
//   i_ex_dst                    : EX-stage destination (load-use detection)
//   i_mem_dst, i_mem_regwrite   : MEM-stage destination and write enable
//   i_wb_dst, i_wb_regwrite     : WB-stage destination and write enable
//   o_fwd                       : forwarding select, MEM beats WB
//   o_ex_hit                    : source matches the EX destination
module fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_used,
  input  logic [REG_AW-1:0] i_ex_dst,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic              i_wb_regwrite,
  output logic [1:0]        o_fwd,
  output logic              o_ex_hit
);

  logic w_live;
  logic w_mem_hit;
  logic w_wb_hit;

  // A source reading $0 or not read at all never creates a dependency.
  assign w_live    = i_used && (i_src != REG_AW'(REG_ZERO));
  assign w_mem_hit = w_live && i_mem_regwrite && (i_mem_dst == i_src);
  assign w_wb_hit  = w_live && i_wb_regwrite  && (i_wb_dst  == i_src);
  assign o_ex_hit  = w_live && (i_ex_dst == i_src);

  always_comb begin
    o_fwd = FWD_NONE;
    if (w_mem_hit)     o_fwd = FWD_MEM;
    else if (w_wb_hit) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard.sv
// Central hazard / forwarding controller for the pipelined MIPS core.
// Ports:
//   clk, reset (async, active-low)
//   id_src_reg/id_src_used           : ID-stage source operands
//   ex_*/mem_*/wb_*                  : downstream stage destination info
//   redirect                         : taken branch/jump resolved in MEM
//   clr_counters                     : synchronous perf counter clear
//   fwd_sel                          : per-source forwarding selects
//   stall_if/id/ex/mem, bubble_ex    : pipeline hold / bubble controls
//   flush                            : pipeline register clears on redirect
//   stall_count, flush_count         : saturating performance counters
module pipeline_hazard
  import mips_pipe_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int REG_AW       = 5,
  parameter int MEM_WAIT     = 2,
  parameter int FLUSH_STAGES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_reg,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         mem_dst,
  input  logic                      mem_regwrite,
  input  logic                      mem_access,
  input  logic [REG_AW-1:0]         wb_dst,
  input  logic                      wb_regwrite,
  input  logic                      redirect,
  input  logic                      clr_counters,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      bubble_ex,
  output logic [FLUSH_STAGES-1:0]   flush,
  output logic [CNT_W-1:0]          stall_count,
  output logic [CNT_W-1:0]          flush_count
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;

  logic [NUM_SRC*2-1:0] w_fwd;
  logic [NUM_SRC-1:0]   w_ex_hit;
  logic                 w_load_use;
  logic                 w_mem_stall;
  logic                 w_redirect_ok;
  logic                 w_lu_ok;
  logic                 w_unused_ok;

  mem_state_e           r_state;
  logic [CW-1:0]        r_cnt;
  logic [CNT_W-1:0]     r_stall_count;
  logic [CNT_W-1:0]     r_flush_count;

  // A load always writes a register, so ex_memread alone identifies it.
  assign w_unused_ok = ex_regwrite;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gen_src
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .i_src          (id_src_reg[gi*REG_AW +: REG_AW]),
      .i_used         (id_src_used[gi]),
      .i_ex_dst       (ex_dst),
      .i_mem_dst      (mem_dst),
      .i_mem_regwrite (mem_regwrite),
      .i_wb_dst       (wb_dst),
      .i_wb_regwrite  (wb_regwrite),
      .o_fwd          (w_fwd[gi*2 +: 2]),
      .o_ex_hit       (w_ex_hit[gi])
    );
  end

  // ex_dst != 0 is implied by o_ex_hit, which already excludes $0.
  assign w_load_use = ex_memread && (|w_ex_hit);

  // The stall is asserted combinationally in IDLE so the first access cycle
  // already holds the pipeline.
  assign w_mem_stall = ((r_state == ST_IDLE) && mem_access && (MEM_WAIT > 0)) ||
                       (r_state == ST_WAIT);

  // Priority: memory stall, then redirect, then load-use.
  assign w_redirect_ok = redirect && !w_mem_stall;
  assign w_lu_ok       = w_load_use && !w_mem_stall && !redirect;

  // Combinational outputs are gated so everything reads 0 while in reset.
  assign fwd_sel     = reset ? w_fwd : '0;
  assign stall_if    = reset && (w_mem_stall || w_lu_ok);
  assign stall_id    = reset && (w_mem_stall || w_lu_ok);
  assign stall_ex    = reset && w_mem_stall;
  assign stall_mem   = reset && w_mem_stall;
  assign bubble_ex   = reset && w_lu_ok;
  assign flush       = {FLUSH_STAGES{reset && w_redirect_ok}};
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

  // Data-memory wait FSM. RELEASE ignores mem_access because the same
  // instruction is still sitting in MEM for its final cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_access && (MEM_WAIT > 0)) begin
            r_cnt   <= CW'(MEM_WAIT - 1);
            r_state <= (MEM_WAIT == 1) ? ST_RELEASE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_RELEASE;
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (clr_counters) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (stall_if && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_redirect_ok && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard.sv
// Scoreboard bench for pipeline_hazard: the stimulus process pushes the
// hand-computed expected outputs of each cycle; a monitor pops and compares
// on the falling edge.
module tb_pipeline_hazard;

  localparam int NUM_SRC      = 2;
  localparam int REG_AW       = 5;
  localparam int MEM_WAIT     = 2;
  localparam int FLUSH_STAGES = 3;
  localparam int CNT_W        = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC*REG_AW-1:0] id_src_reg;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         ex_dst;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic [REG_AW-1:0]         mem_dst;
  logic                      mem_regwrite;
  logic                      mem_access;
  logic [REG_AW-1:0]         wb_dst;
  logic                      wb_regwrite;
  logic                      redirect;
  logic                      clr_counters;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_if, stall_id, stall_ex, stall_mem, bubble_ex;
  logic [FLUSH_STAGES-1:0]   flush;
  logic [CNT_W-1:0]          stall_count;
  logic [CNT_W-1:0]          flush_count;

  always #5 clk = ~clk;

  pipeline_hazard #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MEM_WAIT(MEM_WAIT),
    .FLUSH_STAGES(FLUSH_STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_src_reg(id_src_reg), .id_src_used(id_src_used),
    .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
    .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
    .redirect(redirect), .clr_counters(clr_counters),
    .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .stall_mem(stall_mem), .bubble_ex(bubble_ex),
    .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
  );

  // st packs {stall_if, stall_id, stall_ex, stall_mem, bubble_ex}
  typedef struct {
    string            name;
    logic [3:0]       fwd;
    logic [4:0]       st;
    logic [2:0]       fl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  localparam logic [4:0] ST_NONE = 5'b00000;
  localparam logic [4:0] ST_LU   = 5'b11001;
  localparam logic [4:0] ST_MEM  = 5'b11110;

  exp_t             q[$];
  exp_t             mon_e;
  int               n_vec = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] m_sc  = '0;
  logic [CNT_W-1:0] m_fc  = '0;

  task automatic clear_in();
    id_src_reg   = '0;
    id_src_used  = '0;
    ex_dst       = '0;
    ex_regwrite  = 1'b0;
    ex_memread   = 1'b0;
    mem_dst      = '0;
    mem_regwrite = 1'b0;
    mem_access   = 1'b0;
    wb_dst       = '0;
    wb_regwrite  = 1'b0;
    redirect     = 1'b0;
    clr_counters = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used);
    id_src_reg  = {s1, s0};
    id_src_used = used;
  endtask

  // Push this cycle's expectation; counter expectations come from a running
  // tally of the stall/flush cycles pushed so far.
  task automatic expect_v(input string nm, input logic [3:0] fwd,
                          input logic [4:0] st, input logic [2:0] fl);
    exp_t e;
    if (!reset) begin
      m_sc = '0;
      m_fc = '0;
    end
    e.name = nm;
    e.fwd  = fwd;
    e.st   = st;
    e.fl   = fl;
    e.sc   = m_sc;
    e.fc   = m_fc;
    q.push_back(e);
    if (reset) begin
      if (clr_counters) begin
        m_sc = '0;
        m_fc = '0;
      end else begin
        if (st[4] && m_sc != '1) m_sc = m_sc + 1'b1;
        if (fl != 3'b000 && m_fc != '1) m_fc = m_fc + 1'b1;
      end
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        n_vec++;
        if (fwd_sel !== mon_e.fwd ||
            {stall_if, stall_id, stall_ex, stall_mem, bubble_ex} !== mon_e.st ||
            flush !== mon_e.fl || stall_count !== mon_e.sc ||
            flush_count !== mon_e.fc) begin
          n_bad++;
          $display("FAIL %s: got fwd=%b st=%b fl=%b sc=%0d fc=%0d, want fwd=%b st=%b fl=%b sc=%0d fc=%0d",
                   mon_e.name, fwd_sel,
                   {stall_if, stall_id, stall_ex, stall_mem, bubble_ex},
                   flush, stall_count, flush_count,
                   mon_e.fwd, mon_e.st, mon_e.fl, mon_e.sc, mon_e.fc);
        end else begin
          $display("[%0t] %s: fwd=%b st=%b fl=%b sc=%0d fc=%0d", $time,
                   mon_e.name, fwd_sel,
                   {stall_if, stall_id, stall_ex, stall_mem, bubble_ex},
                   flush, stall_count, flush_count);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear_in();

    // Reset: even with a live forwarding match, outputs are forced to 0.
    cyc(); mem_regwrite = 1'b1; mem_dst = 5'd8; set_src(5'd8, 5'd0, 2'b01);
    expect_v("reset_hold", 4'b0000, ST_NONE, 3'b000);
    cyc(); reset = 1'b1; clear_in();
    expect_v("reset_release", 4'b0000, ST_NONE, 3'b000);

    // Forwarding
    cyc(); mem_regwrite = 1'b1; mem_dst = 5'd8; wb_regwrite = 1'b1; wb_dst = 5'd8;
    set_src(5'd8, 5'd0, 2'b01);
    expect_v("fwd_mem_over_wb", 4'b0001, ST_NONE, 3'b000);
    cyc(); mem_regwrite = 1'b0; set_src(5'd8, 5'd8, 2'b01);
    expect_v("fwd_wb_only_src1_unused", 4'b0010, ST_NONE, 3'b000);
    cyc(); mem_regwrite = 1'b1; set_src(5'd8, 5'd8, 2'b11);
    expect_v("fwd_both_mem", 4'b0101, ST_NONE, 3'b000);
    cyc(); mem_dst = 5'd0; wb_dst = 5'd0; set_src(5'd0, 5'd0, 2'b11);
    expect_v("fwd_reg_zero", 4'b0000, ST_NONE, 3'b000);
    cyc(); mem_dst = 5'd8; wb_dst = 5'd3; set_src(5'd8, 5'd3, 2'b11);
    expect_v("fwd_mixed", 4'b1001, ST_NONE, 3'b000);

    // Load-use
    cyc(); clear_in(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 5'd9;
    set_src(5'd0, 5'd9, 2'b10);
    expect_v("load_use", 4'b0000, ST_LU, 3'b000);
    cyc(); ex_memread = 1'b0; ex_regwrite = 1'b0;
    expect_v("load_use_bubble_gone", 4'b0000, ST_NONE, 3'b000);
    cyc(); ex_memread = 1'b1; ex_regwrite = 1'b1; set_src(5'd0, 5'd9, 2'b01);
    expect_v("load_src_unused", 4'b0000, ST_NONE, 3'b000);
    cyc(); ex_dst = 5'd0; set_src(5'd0, 5'd0, 2'b11);
    expect_v("load_dst_zero", 4'b0000, ST_NONE, 3'b000);

    // Memory wait, back-to-back accesses
    cyc(); clear_in(); mem_access = 1'b1;
    expect_v("mem_idle_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("mem_wait_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("mem_release", 4'b0000, ST_NONE, 3'b000);
    cyc(); expect_v("mem2_idle_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("mem2_wait_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); mem_access = 1'b0;
    expect_v("mem2_release", 4'b0000, ST_NONE, 3'b000);
    cyc(); expect_v("mem_idle", 4'b0000, ST_NONE, 3'b000);

    // Redirect beats load-use
    cyc(); ex_memread = 1'b1; ex_dst = 5'd9; set_src(5'd9, 5'd0, 2'b01); redirect = 1'b1;
    expect_v("redirect_over_lu", 4'b0000, ST_NONE, 3'b111);
    cyc(); clear_in();
    expect_v("after_redirect", 4'b0000, ST_NONE, 3'b000);

    // Redirect held during a memory stall is taken in RELEASE
    cyc(); mem_access = 1'b1; redirect = 1'b1;
    expect_v("redirect_in_idle_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("redirect_in_wait", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("redirect_in_release", 4'b0000, ST_NONE, 3'b111);
    cyc(); clear_in();
    expect_v("after_redirect2", 4'b0000, ST_NONE, 3'b000);

    // Asynchronous reset in the middle of WAIT
    cyc(); mem_access = 1'b1;
    expect_v("mem3_idle_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); reset = 1'b0; mem_regwrite = 1'b1; mem_dst = 5'd4; set_src(5'd4, 5'd0, 2'b01);
    expect_v("reset_mid_wait", 4'b0000, ST_NONE, 3'b000);
    cyc(); reset = 1'b1; clear_in(); mem_access = 1'b1;
    expect_v("post_reset_idle_stall", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("post_reset_wait", 4'b0000, ST_MEM, 3'b000);
    cyc(); expect_v("post_reset_release", 4'b0000, ST_NONE, 3'b000);
    cyc(); mem_access = 1'b0;
    expect_v("post_reset_idle", 4'b0000, ST_NONE, 3'b000);

    // Saturation of stall_count
    for (int i = 0; i < 16; i++) begin
      cyc(); clear_in(); ex_memread = 1'b1; ex_dst = 5'd7; set_src(5'd7, 5'd0, 2'b01);
      expect_v($sformatf("sat_lu_%0d", i), 4'b0000, ST_LU, 3'b000);
    end
    cyc(); clear_in(); redirect = 1'b1;
    expect_v("sat_redirect", 4'b0000, ST_NONE, 3'b111);
    cyc(); clear_in(); ex_memread = 1'b1; ex_dst = 5'd7; set_src(5'd7, 5'd0, 2'b01);
    clr_counters = 1'b1;
    expect_v("clr_with_stall", 4'b0000, ST_LU, 3'b000);
    cyc(); clear_in();
    expect_v("after_clr", 4'b0000, ST_NONE, 3'b000);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) cyc();
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard.md
Name: pipeline_hazard

Overview:
Central hazard and forwarding controller for the pipelined MIPS core. It replaces the constant `hazard(1'b0)` tie-off on the IF stage.
- Generates per-source forwarding selects, load-use stalls and branch/jump flushes.
- Runs a multi-cycle data-memory wait FSM.
- Keeps saturating stall and flush performance counters.
- Generalised over read-port count, register address width, memory latency and flush depth.

Parameters:
NUM_SRC, 2, number of ID-stage register source operands checked
REG_AW, 5, register address width
MEM_WAIT, 2, extra stall cycles per data-memory access (0 = single-cycle memory)
FLUSH_STAGES, 3, number of pipeline registers flushed on a redirect (bit 0 = IF/ID)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_src_reg  in  NUM_SRC*REG_AW  ID-stage source register numbers, source i at [i*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  source i actually read by the ID instruction
ex_dst  in  REG_AW  EX-stage destination register
ex_regwrite  in  1  EX instruction writes a register
ex_memread  in  1  EX instruction is a load
mem_dst  in  REG_AW  MEM-stage destination register
mem_regwrite  in  1  MEM instruction writes a register
mem_access  in  1  MEM instruction is a load or store
wb_dst  in  REG_AW  WB-stage destination register
wb_regwrite  in  1  WB instruction writes a register
redirect  in  1  taken branch, jump or jr resolved in MEM (pcsrc)
clr_counters  in  1  synchronous clear of the performance counters
fwd_sel  out  NUM_SRC*2  per source: 00 regfile, 01 MEM aluout, 10 WB result
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX
stall_mem  out  1  hold EX/MEM
bubble_ex  out  1  load a NOP into ID/EX
flush  out  FLUSH_STAGES  clear the selected pipeline registers
stall_count  out  CNT_W  cycles with stall_if asserted
flush_count  out  CNT_W  accepted redirects

Behaviour:
- Reset: while reset=0, every output is 0, the FSM is in IDLE, the wait counter is 0 and both perf counters are 0. Asynchronous assertion; release takes effect at the next rising edge.
- Forwarding (combinational) for each source i:
  - 01 if mem_regwrite, mem_dst==src, src!=0 and id_src_used[i].
  - Otherwise 10 if the same conditions hold for the WB stage.
  - Otherwise 00.
  - MEM has priority over WB.
- Load-use (combinational): condition is ex_memread, ex_dst!=0, and ex_dst matches any used source.
  - Asserts stall_if, stall_id and bubble_ex for that cycle.
  - Self-clears once the bubble has propagated, giving exactly 1 stall cycle.
- Memory wait FSM, states IDLE / WAIT / RELEASE:
  - IDLE: if mem_access and MEM_WAIT>0, assert mem_stall. Load cnt=MEM_WAIT-1. Next state is RELEASE if MEM_WAIT==1, else WAIT.
  - WAIT: assert mem_stall, decrement cnt. When cnt==1, next state is RELEASE.
  - RELEASE: no stall; mem_access is ignored because the same instruction is still in MEM. Next state is IDLE.
  - Total stall per access is exactly MEM_WAIT cycles.
  - Back-to-back accesses stall again after each RELEASE.
  - MEM_WAIT=0: the FSM never leaves IDLE.
  - mem_stall drives stall_if, stall_id, stall_ex and stall_mem together.
- Priority, highest first:
  1. mem_stall: redirect and load-use are ignored that cycle and re-evaluated later, since the inputs are held.
  2. redirect: flush is all ones for one cycle; stall_if, stall_id and bubble_ex are forced to 0 so the new PC loads.
  3. load-use.
- flush is 0 whenever redirect is not accepted.
- Counters:
  - stall_count increments every cycle stall_if=1.
  - flush_count increments on each accepted redirect.
  - Both saturate at all ones.
  - clr_counters wins over increment that cycle.

Decomposition:
- Shared package mips_pipe_pkg:
  - FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - Memory FSM state encoding (IDLE, WAIT, RELEASE).
  - REG_ZERO constant.
- Sub-module fwd_select: a per-source comparator and priority encoder, instantiated NUM_SRC times with generate.

Test Plan:
1. mem_regwrite=1, mem_dst=8; wb_regwrite=1, wb_dst=8; src0=8 used -> fwd_sel[1:0]=01. Repeat with mem_dst=0 and src0=0 -> 00.
2. ex_memread=1, ex_dst=9, src1=9 used -> stall_if, stall_id and bubble_ex high for 1 cycle; stall_count=1. Repeat with src1 unused -> no stall.
3. MEM_WAIT=2: mem_access held for 3 cycles -> stall_if/id/ex/mem high for cycles 0-1, low in cycle 2 (RELEASE); stall_count=2.
4. Load-use and redirect in the same cycle -> flush=3'b111, stall_if=0, bubble_ex=0; flush_count=1.
5. redirect during mem_stall -> flush stays 0; accepted in the RELEASE cycle.
6. reset driven low mid-WAIT -> all outputs 0 immediately; after release, mem_access restarts a full MEM_WAIT stall. Preload stall_count near all ones -> saturates; clr_counters -> 0.
